// File: rtl/ahb_apb_bridge.sv
// Single-slot AHB-to-APB3 bridge. Each accepted AHB beat becomes one APB
// SETUP/ACCESS cycle on one of four peripheral selects.
module ahb_apb_bridge #(
   parameter int APB_AW   = 16,
   parameter int PSEL_LSB = 12,
   parameter int TIMEOUT  = 16
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              HSELx,
   input  logic [31:0]       HADDR,
   input  logic              HWRITE,
   input  logic [1:0]        HTRANS,
   input  logic [2:0]        HSIZE,
   input  logic [2:0]        HBURST,
   input  logic [31:0]       HWDATA,
   output logic [31:0]       HRDATA,
   output logic              HREADY,
   output logic [1:0]        HRESP,
   output logic [APB_AW-1:0] PADDR,
   output logic [3:0]        PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [31:0]       PWDATA,
   input  logic [31:0]       PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b01;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WDATA  = 3'd1,
      ST_SETUP  = 3'd2,
      ST_ACCESS = 3'd3,
      ST_DONE   = 3'd4,
      ST_ERR1   = 3'd5,
      ST_ERR2   = 3'd6
   } state_t;

   state_t          state_r;
   logic [1:0]      sel_r;
   logic [CW-1:0]   wait_cnt_r;
   logic            accept_s;
   logic            unused_s;

   function automatic logic [3:0] psel_dec(input logic [1:0] idx);
      psel_dec = 4'b0001 << idx;
   endfunction

   // Sizes above a word, or addresses not aligned to the size, get an ERROR
   function automatic logic bad_xfer(input logic [2:0] size, input logic [1:0] lsb);
      case (size)
         3'b000:  bad_xfer = 1'b0;
         3'b001:  bad_xfer = lsb[0];
         3'b010:  bad_xfer = (lsb != 2'b00);
         default: bad_xfer = 1'b1;
      endcase
   endfunction

   assign accept_s = HREADY && HSELx && HTRANS[1];
   assign unused_s = ^{HBURST, HTRANS[0], HADDR};

   // Bridge FSM; every AHB and APB output is a register updated with the state
   always_ff @(posedge HCLK or posedge HRESETn) begin
      if (HRESETn) begin
         state_r    <= ST_IDLE;
         HREADY     <= 1'b1;
         HRESP      <= RESP_OKAY;
         HRDATA     <= 32'h0000_0000;
         PSEL       <= 4'b0000;
         PENABLE    <= 1'b0;
         PWRITE     <= 1'b0;
         PADDR      <= '0;
         PWDATA     <= 32'h0000_0000;
         sel_r      <= 2'b00;
         wait_cnt_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE, ST_ERR2: begin
               PSEL    <= 4'b0000;
               PENABLE <= 1'b0;
               if (accept_s) begin
                  HREADY <= 1'b0;
                  if (bad_xfer(HSIZE, HADDR[1:0])) begin
                     state_r <= ST_ERR1;
                     HRESP   <= RESP_ERROR;
                  end else begin
                     HRESP  <= RESP_OKAY;
                     PADDR  <= HADDR[APB_AW-1:0];
                     PWRITE <= HWRITE;
                     sel_r  <= HADDR[PSEL_LSB+1:PSEL_LSB];
                     if (HWRITE) begin
                        state_r <= ST_WDATA;
                     end else begin
                        state_r    <= ST_SETUP;
                        PSEL       <= psel_dec(HADDR[PSEL_LSB+1:PSEL_LSB]);
                        wait_cnt_r <= '0;
                     end
                  end
               end else begin
                  state_r <= ST_IDLE;
                  HREADY  <= 1'b1;
                  HRESP   <= RESP_OKAY;
               end
            end
            ST_WDATA: begin
               PWDATA     <= HWDATA;
               PSEL       <= psel_dec(sel_r);
               wait_cnt_r <= '0;
               state_r    <= ST_SETUP;
            end
            ST_SETUP: begin
               PENABLE <= 1'b1;
               state_r <= ST_ACCESS;
            end
            ST_ACCESS: begin
               // A PREADY in the final allowed cycle takes priority over the timeout
               if (PREADY) begin
                  PSEL    <= 4'b0000;
                  PENABLE <= 1'b0;
                  if (PSLVERR) begin
                     state_r <= ST_ERR1;
                     HRESP   <= RESP_ERROR;
                  end else begin
                     state_r <= ST_DONE;
                     HREADY  <= 1'b1;
                     if (!PWRITE) begin
                        HRDATA <= PRDATA;
                     end else begin
                        HRDATA <= HRDATA;
                     end
                  end
               end else if (wait_cnt_r == CW'(TIMEOUT - 1)) begin
                  PSEL    <= 4'b0000;
                  PENABLE <= 1'b0;
                  state_r <= ST_ERR1;
                  HRESP   <= RESP_ERROR;
               end else begin
                  wait_cnt_r <= wait_cnt_r + {{(CW-1){1'b0}}, 1'b1};
               end
            end
            ST_ERR1: begin
               state_r <= ST_ERR2;
               HREADY  <= 1'b1;
               HRESP   <= RESP_ERROR;
            end
            default: begin
               state_r <= ST_IDLE;
               HREADY  <= 1'b1;
               HRESP   <= RESP_OKAY;
               PSEL    <= 4'b0000;
               PENABLE <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/ahb_apb_bridge.md
# ahb_apb_bridge

- Single-slot AHB-to-APB bridge on the AHB slave side of the bus fabric.
- Accepts one AHB transfer at a time from the shared HADDR/HWRITE/HTRANS/HSIZE/HWDATA lines when its HSELx is asserted by ahb_decoder.
- Runs an APB3 SETUP/ACCESS cycle on one of four peripheral selects, then returns HRDATA/HREADY/HRESP into the same mux fabric as ahb_slave.
- AHB bursts are serviced as back-to-back single transfers.

## Interface
Parameters:
- APB_AW, 16: PADDR width, taken from HADDR[APB_AW-1:0].
- PSEL_LSB, 12: HADDR[PSEL_LSB+1:PSEL_LSB] selects the PSEL bit.
- TIMEOUT, 16: maximum ACCESS cycles waiting on PREADY before an error is forced.

Ports:
- HCLK  in  1  — bus clock; all state on rising edge.
- HRESETn  in  1  — asynchronous, active-high reset; the name is kept as in the codebase, polarity is active-high.
- HSELx  in  1  — bridge select from decoder.
- HADDR  in  32  — AHB address.
- HWRITE  in  1  — 1 = write.
- HTRANS  in  2  — 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HSIZE  in  3  — transfer size.
- HBURST  in  3  — ignored; each beat is handled as a single.
- HWDATA  in  32  — write data, valid in the first data-phase cycle.
- HRDATA  out  32  — read data.
- HREADY  out  1  — 1 = current data phase completes this cycle.
- HRESP  out  2  — 00 OKAY, 01 ERROR.
- PADDR  out  APB_AW  — APB address.
- PSEL  out  4  — one-hot peripheral select.
- PENABLE  out  1  — APB access phase.
- PWRITE  out  1  — APB direction.
- PWDATA  out  32  — APB write data.
- PRDATA  in  32  — read data from the selected peripheral.
- PREADY  in  1  — peripheral ready.
- PSLVERR  in  1  — peripheral error.

## Operation
- FSM states: IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2.
- Outputs by state:
  - HREADY=1 in IDLE, DONE and ERR2; 0 in all others.
  - HRESP=01 in ERR1 and ERR2; 00 otherwise.
- Accept condition: HREADY=1 && HSELx && HTRANS[1]=1. IDLE and BUSY are never accepted.
- On accept, register HADDR, HWRITE and HSIZE. Next state:
  - ERR1 if HSIZE > 3'b010.
  - ERR1 if HSIZE=001 and HADDR[0]!=0.
  - ERR1 if HSIZE=010 and HADDR[1:0]!=0.
  - Otherwise WDATA for a write, SETUP for a read.
- WDATA: capture HWDATA into PWDATA → SETUP.
- SETUP:
  - PSEL[HADDR[PSEL_LSB+1:PSEL_LSB]]=1, PENABLE=0.
  - PADDR, PWRITE and PWDATA are driven and held stable until leaving ACCESS.
  - Next state: ACCESS.
- ACCESS:
  - PSEL held, PENABLE=1, wait counter increments each cycle.
  - PREADY=1 && !PSLVERR → DONE. On a read, PRDATA is registered into HRDATA on this edge.
  - PREADY=1 && PSLVERR → ERR1.
  - Counter reaches TIMEOUT with PREADY=0 → ERR1. PSEL and PENABLE drop.
- DONE:
  - HREADY=1, HRESP=OKAY, PSEL=0, PENABLE=0.
  - If accept is true this cycle (pipelined next beat), take the accept branch; else → IDLE.
- ERR1 → ERR2 unconditionally. This is the two-cycle ERROR response.
- ERR2:
  - Same accept rule as DONE.
  - A master issuing IDLE here gets no further access.
- HRDATA holds its last value until the next successful read. It is not cleared on writes or errors.
- The wait counter clears on entry to SETUP.

## Timing
- Reset values (asynchronous, immediate on HRESETn=1):
  - State = IDLE.
  - HREADY=1, HRESP=00, HRDATA=0.
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
  - Wait counter = 0.
- Reset mid-transfer aborts the APB cycle in the same instant; no completion is signalled.
- Read latency, zero-wait peripheral:
  - Accept edge T0.
  - T1 SETUP, T2 ACCESS with PREADY=1.
  - T3 DONE: HREADY=1, HRDATA valid.
- Write latency, zero-wait peripheral:
  - T1 WDATA, T2 SETUP, T3 ACCESS.
  - T4 DONE.
- Each PREADY=0 cycle in ACCESS adds one cycle.
- Back-to-back beats: the next accept in DONE/ERR2 puts SETUP (read) or WDATA (write) in the cycle after DONE. PSEL is low for exactly one cycle (DONE) between accesses.
- Timeout: ERR1 is entered after exactly TIMEOUT ACCESS cycles with PREADY=0. A PREADY=1 arriving in that same cycle wins.

## Test plan
- Single read:
  - Stimulus: HADDR=0x0000_1004, HSIZE=010, PRDATA=0xDEAD_BEEF, PREADY tied 1.
  - Required: PSEL=0010, PADDR=0x1004; SETUP then ACCESS; HREADY=1 with HRDATA=0xDEAD_BEEF 3 cycles after accept.
- Single write:
  - Stimulus: HADDR=0x0000_3008, HWDATA=0x1234_5678.
  - Required: PSEL=1000, PWRITE=1, PWDATA=0x1234_5678 stable across SETUP/ACCESS; HREADY=1 4 cycles after accept.
- Wait states and timeout:
  - Stimulus: PREADY low for 3 cycles.
  - Required: DONE 3 cycles later than the zero-wait case.
  - Stimulus: PREADY held low, TIMEOUT=16.
  - Required: ERR1 after 16 ACCESS cycles, HRESP=01 for 2 cycles, HREADY 0 then 1.
- Error paths:
  - Stimulus: PSLVERR=1 with PREADY.
  - Required: two-cycle ERROR response.
  - Stimulus: HSIZE=011, or HSIZE=010 at HADDR=0x2.
  - Required: ERROR response with no PSEL assertion.
- INCR4 read burst:
  - Stimulus: INCR4 read at 0x0, PRDATA=address.
  - Required: four APB reads at 0x0/0x4/0x8/0xC; each HREADY=1 carries the matching data; PSEL low exactly one cycle between them.
- Reset asserted during ACCESS:
  - Required: PSEL, PENABLE and HRESP are 0 and HREADY is 1 immediately; after release, a new read completes normally.
